// File: rtl/spi_slave_engine_if.sv
// ---------------------------------------------------------------------------
// spi_slave_engine_if
//   Host-side handshake bundle for spi_slave_engine.
//   tx_data/tx_load/tx_ready : one-deep TX holding buffer write port
//   rx_data/rx_valid/rx_ack  : received character, completion pulse, consumer ack
//   Modport slave  : seen by the engine.
//   Modport master : seen by the host logic driving the engine.
// ---------------------------------------------------------------------------
interface spi_slave_engine_if #(
    parameter int CHAR_LEN = 8
) ();
    logic [CHAR_LEN-1:0] tx_data;
    logic                tx_load;
    logic                tx_ready;
    logic [CHAR_LEN-1:0] rx_data;
    logic                rx_valid;
    logic                rx_ack;

    modport slave (
        input  tx_data,
        input  tx_load,
        input  rx_ack,
        output tx_ready,
        output rx_data,
        output rx_valid
    );

    modport master (
        output tx_data,
        output tx_load,
        output rx_ack,
        input  tx_ready,
        input  rx_data,
        input  rx_valid
    );
endinterface

// File: rtl/spi_slave_engine.sv
// ---------------------------------------------------------------------------
// spi_slave_engine
//   SPI target-side shift engine running entirely in the wb_clk domain.
//   SCLK, SS_n and MOSI are oversampled through SYNC_STAGES flops plus one
//   delay flop for edge detection. All four CPOL/CPHA modes are supported,
//   back-to-back characters while SS_n stays low, and a one-deep TX holding
//   buffer.
//
// Ports
//   wb_clk, wb_reset   : clock, synchronous active-high reset
//   sclk_i, ss_n_i,
//   mosi_i             : asynchronous SPI pins from the master
//   miso_o, miso_oe    : serial data out and its output enable
//   cpol, cpha,
//   lsb_first          : mode, latched at frame start
//   busy               : frame active
//   overrun            : only with SPI_SLAVE_OVERRUN_EN defined; sticky flag
//                        set when a character completes before rx_ack
//   host               : spi_slave_engine_if.slave (tx/rx handshake)
//
// Optional feature macro: SPI_SLAVE_OVERRUN_EN
// ---------------------------------------------------------------------------
module spi_slave_engine #(
    parameter int CHAR_LEN    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic wb_clk,
    input  logic wb_reset,
    input  logic sclk_i,
    input  logic ss_n_i,
    input  logic mosi_i,
    output logic miso_o,
    output logic miso_oe,
    input  logic cpol,
    input  logic cpha,
    input  logic lsb_first,
    output logic busy,
`ifdef SPI_SLAVE_OVERRUN_EN
    output logic overrun,
`endif
    spi_slave_engine_if.slave host
);

    localparam int CW = (CHAR_LEN > 2) ? $clog2(CHAR_LEN) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(CHAR_LEN - 1);
    // Pin vector order {mosi, ss_n, sclk}; ss_n idles high after reset so
    // no false frame start is seen when reset releases.
    localparam logic [2:0] PIN_RST = 3'b010;

    typedef enum logic {IDLE, ACTIVE} state_t;

    // ---------------- input synchronisers ----------------
    logic [2:0] pin_vec;
    logic [2:0] sync_reg [SYNC_STAGES];
    logic [2:0] dly_reg;

    assign pin_vec = {mosi_i, ss_n_i, sclk_i};

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge wb_clk) begin
                    if (wb_reset) sync_reg[gi] <= PIN_RST;
                    else          sync_reg[gi] <= pin_vec;
                end
            end else begin : g_rest
                always_ff @(posedge wb_clk) begin
                    if (wb_reset) sync_reg[gi] <= PIN_RST;
                    else          sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge wb_clk) begin
        if (wb_reset) dly_reg <= PIN_RST;
        else          dly_reg <= sync_reg[SYNC_STAGES-1];
    end

    logic sclk_s, ss_s, mosi_s, sclk_d, ss_d;
    assign sclk_s = sync_reg[SYNC_STAGES-1][0];
    assign ss_s   = sync_reg[SYNC_STAGES-1][1];
    assign mosi_s = sync_reg[SYNC_STAGES-1][2];
    assign sclk_d = dly_reg[0];
    assign ss_d   = dly_reg[1];

    // ---------------- state ----------------
    state_t              state_reg;
    logic [CW-1:0]       bit_cnt_reg;
    logic                load_pending_reg;
    logic                rx_pending_reg;
    logic                cpol_reg, cpha_reg, lsb_reg;
    logic [CHAR_LEN-1:0] tx_shreg_reg;
    logic [CHAR_LEN-1:0] rx_shreg_reg;
    logic [CHAR_LEN-1:0] rx_data_reg;
    logic                rx_valid_reg;
    logic                miso_reg, miso_oe_reg, busy_reg;
    logic [CHAR_LEN-1:0] hold_reg;
    logic                hold_full_reg;

    // ---------------- event decode ----------------
    logic                sclk_rise, sclk_fall, lead_edge, trail_edge;
    logic                frame_start, frame_end, shift_ev, sample_ev;
    logic                char_done, tx_take;
    logic [CHAR_LEN-1:0] load_word, rx_next;

    always_comb begin
        sclk_rise   = sclk_s & ~sclk_d;
        sclk_fall   = ~sclk_s & sclk_d;
        lead_edge   = cpol_reg ? sclk_fall : sclk_rise;
        trail_edge  = cpol_reg ? sclk_rise : sclk_fall;
        frame_start = (state_reg == IDLE) && !ss_s && ss_d;
        frame_end   = (state_reg == ACTIVE) && ss_s;
        // SS_n high wins over any SCLK edge detected in the same cycle.
        shift_ev    = (state_reg == ACTIVE) && !ss_s && (cpha_reg ? lead_edge : trail_edge);
        sample_ev   = (state_reg == ACTIVE) && !ss_s && (cpha_reg ? trail_edge : lead_edge);
        char_done   = sample_ev && (bit_cnt_reg == LAST_BIT);
        tx_take     = (frame_start && !cpha) || (shift_ev && load_pending_reg);
        load_word   = hold_full_reg ? hold_reg : '0;
        rx_next     = lsb_reg ? {mosi_s, rx_shreg_reg[CHAR_LEN-1:1]}
                              : {rx_shreg_reg[CHAR_LEN-2:0], mosi_s};
    end

    // ---------------- TX holding buffer ----------------
    // A take in the same cycle as an accepted write sees the old (empty)
    // contents; the write lands afterwards and leaves the buffer full.
    always_ff @(posedge wb_clk) begin
        if (wb_reset) begin
            hold_reg      <= '0;
            hold_full_reg <= 1'b0;
        end else begin
            if (tx_take) hold_full_reg <= 1'b0;
            if (host.tx_load && !hold_full_reg) begin
                hold_reg      <= host.tx_data;
                hold_full_reg <= 1'b1;
            end
        end
    end

    // ---------------- frame FSM ----------------
    always_ff @(posedge wb_clk) begin
        if (wb_reset) begin
            state_reg        <= IDLE;
            bit_cnt_reg      <= '0;
            load_pending_reg <= 1'b0;
            cpol_reg         <= 1'b0;
            cpha_reg         <= 1'b0;
            lsb_reg          <= 1'b0;
            tx_shreg_reg     <= '0;
            rx_shreg_reg     <= '0;
            rx_data_reg      <= '0;
            rx_valid_reg     <= 1'b0;
            miso_reg         <= 1'b0;
            miso_oe_reg      <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (frame_start) begin
                        state_reg    <= ACTIVE;
                        bit_cnt_reg  <= '0;
                        miso_oe_reg  <= 1'b1;
                        busy_reg     <= 1'b1;
                        cpol_reg     <= cpol;
                        cpha_reg     <= cpha;
                        lsb_reg      <= lsb_first;
                        rx_shreg_reg <= '0;
                        if (!cpha) begin
                            // Bit 0 must be on MISO before the first leading edge.
                            tx_shreg_reg     <= load_word;
                            miso_reg         <= lsb_first ? load_word[0] : load_word[CHAR_LEN-1];
                            load_pending_reg <= 1'b0;
                        end else begin
                            load_pending_reg <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (frame_end) begin
                        state_reg        <= IDLE;
                        bit_cnt_reg      <= '0;
                        load_pending_reg <= 1'b0;
                        tx_shreg_reg     <= '0;
                        miso_reg         <= 1'b0;
                        miso_oe_reg      <= 1'b0;
                        busy_reg         <= 1'b0;
                    end else begin
                        if (shift_ev) begin
                            if (load_pending_reg) begin
                                tx_shreg_reg     <= load_word;
                                miso_reg         <= lsb_reg ? load_word[0] : load_word[CHAR_LEN-1];
                                load_pending_reg <= 1'b0;
                            end else if (lsb_reg) begin
                                tx_shreg_reg <= {1'b0, tx_shreg_reg[CHAR_LEN-1:1]};
                                miso_reg     <= tx_shreg_reg[1];
                            end else begin
                                tx_shreg_reg <= {tx_shreg_reg[CHAR_LEN-2:0], 1'b0};
                                miso_reg     <= tx_shreg_reg[CHAR_LEN-2];
                            end
                        end
                        if (sample_ev) begin
                            rx_shreg_reg <= rx_next;
                            if (char_done) begin
                                rx_data_reg      <= rx_next;
                                rx_valid_reg     <= 1'b1;
                                bit_cnt_reg      <= '0;
                                // Next character's bit 0 goes out on the next shift edge.
                                load_pending_reg <= 1'b1;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 1'b1;
                            end
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ---------------- RX bookkeeping ----------------
    always_ff @(posedge wb_clk) begin
        if (wb_reset) begin
            rx_pending_reg <= 1'b0;
        end else if (char_done) begin
            rx_pending_reg <= 1'b1;
        end else if (host.rx_ack && rx_pending_reg) begin
            rx_pending_reg <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic overrun_reg;

    always_ff @(posedge wb_clk) begin
        if (wb_reset) begin
            overrun_reg <= 1'b0;
        end else if (char_done && rx_pending_reg) begin
            overrun_reg <= 1'b1;
        end else if (host.rx_ack) begin
            overrun_reg <= 1'b0;
        end
    end

    assign overrun = overrun_reg;
`endif

    assign miso_o        = miso_reg;
    assign miso_oe       = miso_oe_reg;
    assign busy          = busy_reg;
    assign host.tx_ready = ~hold_full_reg;
    assign host.rx_data  = rx_data_reg;
    assign host.rx_valid = rx_valid_reg;

endmodule

// File: tb/tb_spi_slave_engine.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_engine
//   Bench-side SPI master driving the engine in all four modes. Expected RX
//   characters go into a queue when a frame is issued; a monitor process pops
//   and compares on every rx_valid pulse. MISO is collected by the master and
//   compared per character against the word it expects.
// ---------------------------------------------------------------------------
module tb_spi_slave_engine;

    localparam int HALF = 6;

    logic wb_clk = 1'b0;
    logic wb_reset = 1'b1;
    logic sclk_i = 1'b0;
    logic ss_n_i = 1'b1;
    logic mosi_i = 1'b0;
    logic cpol = 1'b0;
    logic cpha = 1'b0;
    logic lsb_first = 1'b0;
    logic miso_o, miso_oe, busy;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic overrun;
`endif

    int total = 0;
    int bad = 0;
    logic [7:0] rx_q [$];

    spi_slave_engine_if #(.CHAR_LEN(8)) host_if ();

    spi_slave_engine #(.CHAR_LEN(8), .SYNC_STAGES(2)) dut (
        .wb_clk    (wb_clk),
        .wb_reset  (wb_reset),
        .sclk_i    (sclk_i),
        .ss_n_i    (ss_n_i),
        .mosi_i    (mosi_i),
        .miso_o    (miso_o),
        .miso_oe   (miso_oe),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .busy      (busy),
`ifdef SPI_SLAVE_OVERRUN_EN
        .overrun   (overrun),
`endif
        .host      (host_if.slave)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic int bidx(input int i);
        return (i / 8) * 8 + (lsb_first ? (i % 8) : (7 - (i % 8)));
    endfunction

    // RX monitor / scoreboard
    initial begin
        logic prev_valid;
        logic [7:0] e;
        prev_valid = 1'b0;
        forever begin
            @(negedge wb_clk);
            if (!wb_reset && host_if.rx_valid) begin
                if (rx_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected: got=%0h want=none", host_if.rx_data);
                end else begin
                    e = rx_q.pop_front();
                    $display("rx char %02h (expected %02h)", host_if.rx_data, e);
                    chk("rx_data", {24'd0, host_if.rx_data}, {24'd0, e});
                    chk("rx_pulse_width", {31'd0, prev_valid}, 32'd0);
                end
            end
            prev_valid = host_if.rx_valid;
        end
    end

    task automatic load_tx(input logic [7:0] v);
        @(negedge wb_clk);
        host_if.tx_data = v;
        host_if.tx_load = 1'b1;
        @(negedge wb_clk);
        host_if.tx_load = 1'b0;
        $display("tx load %02h", v);
        chk("tx_ready_lo", {31'd0, host_if.tx_ready}, 32'd0);
    endtask

    // One SS_n-low frame of nbits bits; char k of MOSI is mo[8k+7:8k].
    task automatic xfer(input int nbits, input logic [15:0] mo, input logic [15:0] mi,
                        input bit chk_ready, input string tag);
        logic [15:0] got;
        got = '0;
        @(negedge wb_clk);
        sclk_i = cpol;
        ss_n_i = 1'b0;
        if (!cpha) mosi_i = mo[bidx(0)];
        repeat (HALF) @(negedge wb_clk);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        chk({tag, "_miso_oe"}, {31'd0, miso_oe}, 32'd1);
        if (chk_ready) chk({tag, "_tx_ready"}, {31'd0, host_if.tx_ready}, 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                got[bidx(i)] = miso_o;
                sclk_i = ~cpol;
                repeat (HALF) @(negedge wb_clk);
                sclk_i = cpol;
                if (i + 1 < nbits) mosi_i = mo[bidx(i + 1)];
                repeat (HALF) @(negedge wb_clk);
            end else begin
                sclk_i = ~cpol;
                mosi_i = mo[bidx(i)];
                repeat (HALF) @(negedge wb_clk);
                got[bidx(i)] = miso_o;
                sclk_i = cpol;
                repeat (HALF) @(negedge wb_clk);
            end
            if (i % 8 == 7) begin
                $display("frame %s char %0d miso=%02h", tag, i / 8, got[(i/8)*8 +: 8]);
                chk({tag, "_miso"}, {24'd0, got[(i/8)*8 +: 8]}, {24'd0, mi[(i/8)*8 +: 8]});
            end
        end
        ss_n_i = 1'b1;
        mosi_i = 1'b0;
        repeat (4) @(negedge wb_clk);
        chk({tag, "_end_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_end_oe"}, {31'd0, miso_oe}, 32'd0);
        repeat (6) @(negedge wb_clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        host_if.tx_data = '0;
        host_if.tx_load = 1'b0;
        host_if.rx_ack  = 1'b0;

        // Reset state
        repeat (3) @(negedge wb_clk);
        chk("rst_miso", {31'd0, miso_o}, 32'd0);
        chk("rst_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_tx_ready", {31'd0, host_if.tx_ready}, 32'd1);
        chk("rst_rx_data", {24'd0, host_if.rx_data}, 32'd0);
        chk("rst_rx_valid", {31'd0, host_if.rx_valid}, 32'd0);
        wb_reset = 1'b0;
        repeat (3) @(negedge wb_clk);

        // Mode 0, MSB first
        load_tx(8'hA5);
        rx_q.push_back(8'h3C);
        xfer(8, 16'h003C, 16'h00A5, 1'b1, "mode0");

        // Modes 1..3, LSB first
        for (int m = 1; m < 4; m++) begin
            cpol = m[1];
            cpha = m[0];
            lsb_first = 1'b1;
            sclk_i = cpol;
            repeat (4) @(negedge wb_clk);
            load_tx(8'hA5);
            rx_q.push_back(8'h3C);
            xfer(8, 16'h003C, 16'h00A5, !cpha, $sformatf("mode%0d", m));
        end

        // Back-to-back characters, buffer refilled mid-frame
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; sclk_i = 1'b0;
        repeat (4) @(negedge wb_clk);
        load_tx(8'h55);
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        fork
            xfer(16, 16'h2211, 16'hAA55, 1'b0, "b2b");
            begin
                for (int k = 0; k < 200 && !host_if.tx_ready; k++) @(negedge wb_clk);
                chk("b2b_ready_seen", {31'd0, host_if.tx_ready}, 32'd1);
                load_tx(8'hAA);
            end
        join

        // Empty TX buffer
        rx_q.push_back(8'h96);
        xfer(8, 16'h0096, 16'h0000, 1'b1, "empty");

        // Abort after 5 bits, then a clean frame
        xfer(5, 16'h001F, 16'h0000, 1'b0, "abort");
        rx_q.push_back(8'h81);
        xfer(8, 16'h0081, 16'h0000, 1'b1, "after_abort");

        // Reset mid-frame
        load_tx(8'h5A);
        @(negedge wb_clk);
        ss_n_i = 1'b0;
        repeat (HALF) @(negedge wb_clk);
        for (int i = 0; i < 3; i++) begin
            sclk_i = 1'b1;
            repeat (HALF) @(negedge wb_clk);
            sclk_i = 1'b0;
            repeat (HALF) @(negedge wb_clk);
        end
        chk("mid_busy_pre", {31'd0, busy}, 32'd1);
        wb_reset = 1'b1;
        @(negedge wb_clk);
        $display("mid-frame reset applied");
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_oe", {31'd0, miso_oe}, 32'd0);
        chk("mid_rst_miso", {31'd0, miso_o}, 32'd0);
        chk("mid_rst_tx_ready", {31'd0, host_if.tx_ready}, 32'd1);
        chk("mid_rst_rx_data", {24'd0, host_if.rx_data}, 32'd0);
        chk("mid_rst_rx_valid", {31'd0, host_if.rx_valid}, 32'd0);
`ifdef SPI_SLAVE_OVERRUN_EN
        chk("mid_rst_overrun", {31'd0, overrun}, 32'd0);
`endif
        ss_n_i = 1'b1;
        sclk_i = 1'b0;
        repeat (2) @(negedge wb_clk);
        wb_reset = 1'b0;
        repeat (5) @(negedge wb_clk);

`ifdef SPI_SLAVE_OVERRUN_EN
        // Two characters with no rx_ack in between
        rx_q.push_back(8'h11);
        rx_q.push_back(8'h22);
        xfer(16, 16'h2211, 16'h0000, 1'b1, "ovr");
        chk("ovr_set", {31'd0, overrun}, 32'd1);
        chk("ovr_rx_data", {24'd0, host_if.rx_data}, 32'h22);
        @(negedge wb_clk);
        host_if.rx_ack = 1'b1;
        @(negedge wb_clk);
        host_if.rx_ack = 1'b0;
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);
`endif

        repeat (5) @(negedge wb_clk);
        chk("rx_queue_empty", rx_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
